spi_peripheral: RTL
===================

Name: spi_peripheral

Overview:
SPI responder (target) for the CPU SPI link: the far-end counterpart of the CPU-side SPI initiator. It sits on the peripheral side and samples the initiator's spi_clk, ss_n and MOSI using the local system clock. It shifts received MOSI bits into a parallel word and shifts a CPU-supplied word out on MISO. Mode 0 only (CPOL=0, CPHA=0), MSB first, one word per W_Data clocks, with back-to-back words allowed while ss_n stays low.

Parameters:
W_Data, 32, word width in bits (matches `W_CPU)
W_Counter, 5, bit counter width; must satisfy 2^W_Counter >= W_Data
FILL_WORD, 0, word shifted out on MISO when no transmit word is loaded (underrun)

Ports:
clk  input  1  system clock; spi_clk must be <= clk/4
rst  input  1  asynchronous reset, active-low
tx_data  input  W_Data  word to send on MISO
tx_valid  input  1  tx_data offered; accepted when tx_valid && tx_ready
tx_ready  output  1  transmit holding register empty
rx_data  output  W_Data  last complete word received on MOSI
rx_valid  output  1  one-cycle pulse; rx_data is new
tx_underrun  output  1  one-cycle pulse; a word started with the holding register empty
frame_abort  output  1  one-cycle pulse; ss_n rose mid-word
spi_clk  input  1  SPI clock from initiator (asynchronous)
ss_n  input  1  slave select, active-low (asynchronous)
MOSI_in  input  1  serial data from initiator
MISO_out  output  1  serial data to initiator
miso_oe  output  1  MISO drive enable (synchronised ss_n low)

Behaviour:
- Reset (rst=0, asynchronous): tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, MISO_out=0, miso_oe=0. Holding register is empty, bit counter=0, state=IDLE, and synchroniser flops are set to spi_clk=0 and ss_n=1.
- Synchronisation: spi_clk, ss_n and MOSI_in each pass through 2 flops, plus a 3rd flop on spi_clk and ss_n for edge detection.
  - sclk_rise/sclk_fall and ss_fall/ss_rise are single-cycle strobes.
- Holding register: on tx_valid && tx_ready, capture tx_data and set tx_ready=0 on the next edge. tx_ready returns to 1 the cycle after the shift register consumes the word.
- FSM states:
  - IDLE: MISO_out=0, miso_oe=0. On ss_fall go to LOAD. A low ss_n without a falling edge (e.g. low coming out of reset) does not start a frame.
  - LOAD (1 cycle): shift_tx <= hold if full, else FILL_WORD with tx_underrun pulse. Bit counter=0, miso_oe=1, MISO_out=MSB of the loaded word. Next state SHIFT.
  - SHIFT:
    - On sclk_rise: shift_rx <= {shift_rx[W_Data-2:0], MOSI_sync}; counter++.
    - When the counter reaches W_Data-1 on a rise: next cycle rx_data <= completed word and rx_valid=1 for exactly one cycle, counter wraps to 0.
    - On sclk_fall: if counter != 0, shift shift_tx left and drive its new MSB on MISO_out.
    - If counter == 0 after a completed word, reload as in LOAD (hold or FILL_WORD + underrun) on that fall, for back-to-back words.
    - On ss_rise go to IDLE. If counter != 0, pulse frame_abort and discard the partial word (no rx_valid, rx_data unchanged). A loaded-but-unsent transmit word is lost; the holding register is unaffected.
- Latency:
  - MSB is on MISO_out 4 clk after the ss_n pin falls; the initiator must wait >= 4 clk before the first spi_clk rise.
  - rx_valid is asserted 4 clk after the pin-level last spi_clk rise.
- Simultaneous events:
  - tx_valid in the same cycle as LOAD/reload: the load uses the hold contents registered before that edge.
  - If hold was empty, the new word goes into hold for the next word.
  - sclk_rise and ss_rise in the same cycle: ss_rise wins (abort rules apply).
- Reset mid-frame: everything returns to reset values immediately; the frame is not resumed.
- rx has no backpressure: a new word overwrites rx_data.

Test Plan:
- Reset then tx 0xA5A5_0F0F, ss_n low, 32 mode-0 clocks of MOSI 0x1234_5678 at clk/8 -> MISO bits equal 0xA5A50F0F MSB first; one rx_valid pulse with rx_data=0x12345678; tx_ready high again after load.
- No tx word loaded, one 32-bit frame -> tx_underrun pulses once; MISO all 0 (FILL_WORD); rx still valid.
- Two back-to-back words with ss_n held low, tx 0x0000_0001 then 0x8000_0000 offered before the second reload -> MISO matches both; two rx_valid pulses exactly 32 spi_clk apart; no underrun.
- ss_n raised after 10 bits -> frame_abort pulse; no rx_valid; rx_data unchanged; next frame receives correctly from bit 31.
- rst pulsed low mid-word, ss_n kept low -> outputs at reset values; no frame until ss_n rises then falls.
- tx_valid held with tx_ready=0 -> word not accepted until the hold empties; accepted word appears intact in the next frame.

Source files
------------

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 responder, oversampled by the local system clock
module spi_peripheral #(
  parameter int                W_Data    = 32,
  parameter int                W_Counter = 5,
  parameter logic [W_Data-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_Data-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_Data-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  input  logic              spi_clk,
  input  logic              ss_n,
  input  logic              MOSI_in,
  output logic              MISO_out,
  output logic              miso_oe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  logic [2:0]           r_sclk_sync;
  logic [2:0]           r_ss_sync;
  logic [1:0]           r_mosi_sync;
  logic [1:0]           r_settle;
  logic                 r_ss_armed;

  state_t               r_state;
  logic [W_Data-1:0]    r_hold;
  logic                 r_tx_ready;
  logic [W_Data-2:0]    r_shift_tx;
  logic [W_Data-1:0]    r_shift_rx;
  logic [W_Counter-1:0] r_count;
  logic                 r_word_done;
  logic [W_Data-1:0]    r_rx_data;
  logic                 r_rx_valid;
  logic                 r_underrun;
  logic                 r_abort;
  logic                 r_miso;
  logic                 r_oe;

  logic                 w_sclk_rise;
  logic                 w_sclk_fall;
  logic                 w_ss_fall;
  logic                 w_ss_rise;
  logic                 w_mosi;
  logic                 w_accept;
  logic                 w_reload;
  logic                 w_load;
  logic [W_Data-1:0]    w_load_word;

  // A frame may only start once ss_n has been seen high with real samples,
  // so a select line already low when reset releases is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= 3'b000;
      r_ss_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
      r_settle    <= 2'b00;
      r_ss_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], spi_clk};
      r_ss_sync   <= {r_ss_sync[1:0], ss_n};
      r_mosi_sync <= {r_mosi_sync[0], MOSI_in};
      r_settle    <= {r_settle[0], 1'b1};
      if (r_settle[1] && r_ss_sync[1]) begin
        r_ss_armed <= 1'b1;
      end
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ss_fall   = r_ss_armed & r_ss_sync[2] & ~r_ss_sync[1];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_mosi      = r_mosi_sync[1];

  assign w_accept    = tx_valid & r_tx_ready;
  assign w_reload    = (r_state == S_SHIFT) & ~w_ss_rise & w_sclk_fall & (r_count == '0);
  assign w_load      = (r_state == S_LOAD) | w_reload;
  assign w_load_word = r_tx_ready ? FILL_WORD : r_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_tx_ready  <= 1'b1;
      r_shift_tx  <= '0;
      r_shift_rx  <= '0;
      r_count     <= '0;
      r_word_done <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      r_rx_valid  <= r_word_done;
      r_word_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
      if (r_word_done) begin
        r_rx_data <= r_shift_rx;
      end

      // Accept only into an empty hold, consume only a full one: never both.
      if (w_accept) begin
        r_hold     <= tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_load && !r_tx_ready) begin
        r_tx_ready <= 1'b1;
      end

      if (w_load) begin
        r_shift_tx <= w_load_word[W_Data-2:0];
        r_miso     <= w_load_word[W_Data-1];
        r_underrun <= r_tx_ready;
      end

      case (r_state)
        S_IDLE: begin
          r_miso  <= 1'b0;
          r_oe    <= 1'b0;
          r_count <= '0;
          if (w_ss_fall) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= '0;
          r_oe    <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_miso  <= 1'b0;
            r_count <= '0;
            if (r_count != '0) begin
              r_abort <= 1'b1;
            end
          end else begin
            if (w_sclk_rise) begin
              r_shift_rx <= {r_shift_rx[W_Data-2:0], w_mosi};
              if (r_count == W_Counter'(W_Data - 1)) begin
                r_count     <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_count <= r_count + W_Counter'(1);
              end
            end
            if (w_sclk_fall && (r_count != '0)) begin
              r_shift_tx <= {r_shift_tx[W_Data-3:0], 1'b0};
              r_miso     <= r_shift_tx[W_Data-2];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;
  assign MISO_out    = r_miso;
  assign miso_oe     = r_oe;

endmodule
